// File: rtl/pwm_output_guard_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_output_guard_if
// Purpose  : Controller/PWM-side bundle for the PWM output guard.
// Revision : 1.0
// ============================================================================
interface pwm_output_guard_if #(
    parameter int WIDTH     = 13,
    parameter int TRANS_NUM = 249
);
    logic                                enable;
    logic                                force_off;
    logic                                clear;
    logic [TRANS_NUM-1:0][WIDTH-1:0]     cycle;
    logic [TRANS_NUM-1:0]                pwm_in;
    logic [TRANS_NUM-1:0]                pwm_out;
    logic [TRANS_NUM-1:0]                fault;
    logic                                fault_any;
    logic [7:0]                          fault_cnt;
    logic [1:0]                          state;

    modport master (
        output enable, force_off, clear, cycle, pwm_in,
        input  pwm_out, fault, fault_any, fault_cnt, state
    );

    modport slave (
        input  enable, force_off, clear, cycle, pwm_in,
        output pwm_out, fault, fault_any, fault_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/pwm_output_guard.sv
`default_nettype none
// ============================================================================
// Module   : pwm_output_guard
// Purpose  : Caps per-channel PWM high time at CYCLE>>1, latches offenders off
//            and sequences global OFF/ARM/RUN/HALT output gating.
// Revision : 1.0
// ============================================================================
module pwm_output_guard #(
    parameter int WIDTH     = 13,
    parameter int TRANS_NUM = 249
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pwm_output_guard_if.slave  bus
);
    localparam logic [1:0] c_st_off  = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_halt = 2'd3;

    localparam logic [WIDTH-1:0] c_hc_one = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_hc_max = {WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_run;
    logic [TRANS_NUM-1:0] w_viol;
    logic [TRANS_NUM-1:0] r_fault;
    logic [TRANS_NUM-1:0] r_pwm_out;
    logic [7:0]           r_fault_cnt;
    logic                 w_fault_rise;
    logic                 w_pwm_idle;

    generate
        for (genvar i = 0; i < TRANS_NUM; i++) begin : g_ch
            logic [WIDTH-1:0] r_hc;
            logic [WIDTH-1:0] w_limit;

            assign w_limit   = bus.cycle[i] >> 1;
            assign w_viol[i] = bus.pwm_in[i] & (r_hc >= w_limit);

            always_ff @(posedge clk) begin
                if (rst || bus.clear || !bus.pwm_in[i]) begin
                    r_hc <= '0;
                end else if (r_hc != c_hc_max) begin
                    r_hc <= r_hc + c_hc_one;
                end
            end
        end
    endgenerate

    // Counted once per cycle in which any channel newly faults.
    assign w_fault_rise = |(w_viol & ~r_fault);
    assign w_pwm_idle   = ~|bus.pwm_in;

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_fault     <= '0;
            r_fault_cnt <= 8'd0;
        end else begin
            r_fault <= r_fault | w_viol;
            if (w_fault_rise && (r_fault_cnt != 8'hFF)) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end
    end

    // Uses the pre-clear fault value so a clearing cycle never leaks a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_out <= '0;
        end else begin
            r_pwm_out <= bus.pwm_in & ~r_fault & ~w_viol & {TRANS_NUM{w_run}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_off;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.force_off) begin
            w_state_next = c_st_halt;
        end else begin
            case (r_state)
                c_st_off: begin
                    if (bus.enable) w_state_next = c_st_arm;
                end
                c_st_arm: begin
                    // Wait for a quiet cycle so the first driven pulse is whole.
                    if (!bus.enable)     w_state_next = c_st_off;
                    else if (w_pwm_idle) w_state_next = c_st_run;
                end
                c_st_run: begin
                    if (!bus.enable) w_state_next = c_st_off;
                end
                c_st_halt: begin
                    if (bus.clear) w_state_next = c_st_off;
                end
                default: w_state_next = c_st_off;
            endcase
        end
    end

    always_comb begin
        w_run = (r_state == c_st_run);
    end

    assign bus.pwm_out   = r_pwm_out;
    assign bus.fault     = r_fault;
    assign bus.fault_any = |r_fault;
    assign bus.fault_cnt = r_fault_cnt;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_output_guard
// Purpose  : Self-checking bench for pwm_output_guard (vector table + sequences).
// Revision : 1.0
// ============================================================================
module tb_pwm_output_guard;
    localparam int WIDTH     = 13;
    localparam int TRANS_NUM = 249;
    localparam int NVEC      = 29;

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    typedef struct packed {
        logic       en;
        logic       fo;
        logic       clr;
        logic [7:0] pwm;
        logic [1:0] st;
        logic [7:0] out;
        logic [7:0] flt;
        logic [7:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t tbl [NVEC];
    vec_t sb  [$];

    pwm_output_guard_if #(.WIDTH(WIDTH), .TRANS_NUM(TRANS_NUM)) bus ();

    pwm_output_guard #(.WIDTH(WIDTH), .TRANS_NUM(TRANS_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic fo, input logic clr,
                                input logic [7:0] pwm, input logic [1:0] st,
                                input logic [7:0] out, input logic [7:0] flt,
                                input logic [7:0] cnt);
        vec_t v;
        v.en = en; v.fo = fo; v.clr = clr; v.pwm = pwm;
        v.st = st; v.out = out; v.flt = flt; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic fo, input logic clr,
                         input logic [TRANS_NUM-1:0] pwm);
        bus.enable    = en;
        bus.force_off = fo;
        bus.clear     = clr;
        bus.pwm_in    = pwm;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        drive(v.en, v.fo, v.clr, {{(TRANS_NUM-8){1'b0}}, v.pwm});
        sb.push_back(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk($sformatf("v%0d_state", idx), bus.state,     e.st);
        chk($sformatf("v%0d_out",   idx), bus.pwm_out,   e.out);
        chk($sformatf("v%0d_fault", idx), bus.fault,     e.flt);
        chk($sformatf("v%0d_any",   idx), bus.fault_any, |e.flt);
        chk($sformatf("v%0d_cnt",   idx), bus.fault_cnt, e.cnt);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int hi_cnt;
        int mism;
        logic [TRANS_NUM-1:0] p5;
        logic [TRANS_NUM-1:0] p3;

        errors = 0;
        checks = 0;
        p5 = '0; p5[5] = 1'b1;
        p3 = '0; p3[3] = 1'b1;

        // Channels 0..7: limit 2 ticks, except ch3/ch5 (2048) and ch6 (limit 0).
        bus.cycle = '0;
        for (int i = 0; i < 8; i++) bus.cycle[i] = 13'd4;
        bus.cycle[3] = 13'd4096;
        bus.cycle[5] = 13'd4096;
        bus.cycle[6] = 13'd1;

        //            en fo clr pwm    state out    fault  cnt
        tbl[0]  = mk(1, 0, 0, 8'h00, ARM,  8'h00, 8'h00, 8'd0);
        tbl[1]  = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h00, 8'd0);
        tbl[2]  = mk(1, 0, 0, 8'h02, RUN,  8'h02, 8'h00, 8'd0);
        tbl[3]  = mk(1, 0, 0, 8'h02, RUN,  8'h02, 8'h00, 8'd0);
        tbl[4]  = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h00, 8'd0);
        tbl[5]  = mk(1, 0, 0, 8'h81, RUN,  8'h81, 8'h00, 8'd0);
        tbl[6]  = mk(1, 0, 0, 8'h81, RUN,  8'h81, 8'h00, 8'd0);
        tbl[7]  = mk(1, 0, 0, 8'h81, RUN,  8'h00, 8'h81, 8'd1);
        tbl[8]  = mk(1, 0, 0, 8'h81, RUN,  8'h00, 8'h81, 8'd1);
        tbl[9]  = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h81, 8'd1);
        tbl[10] = mk(1, 0, 1, 8'h01, RUN,  8'h00, 8'h00, 8'd0);
        tbl[11] = mk(1, 0, 0, 8'h01, RUN,  8'h01, 8'h00, 8'd0);
        tbl[12] = mk(1, 0, 0, 8'h01, RUN,  8'h01, 8'h00, 8'd0);
        tbl[13] = mk(1, 0, 0, 8'h01, RUN,  8'h00, 8'h01, 8'd1);
        tbl[14] = mk(0, 0, 0, 8'h00, OFF,  8'h00, 8'h01, 8'd1);
        tbl[15] = mk(0, 0, 1, 8'h00, OFF,  8'h00, 8'h00, 8'd0);
        tbl[16] = mk(1, 0, 0, 8'h00, ARM,  8'h00, 8'h00, 8'd0);
        tbl[17] = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h00, 8'd0);
        tbl[18] = mk(1, 0, 0, 8'h04, RUN,  8'h04, 8'h00, 8'd0);
        tbl[19] = mk(1, 1, 0, 8'h04, HALT, 8'h04, 8'h00, 8'd0);
        tbl[20] = mk(1, 1, 0, 8'h00, HALT, 8'h00, 8'h00, 8'd0);
        tbl[21] = mk(1, 1, 1, 8'h00, HALT, 8'h00, 8'h00, 8'd0);
        tbl[22] = mk(1, 0, 1, 8'h00, OFF,  8'h00, 8'h00, 8'd0);
        tbl[23] = mk(1, 0, 0, 8'h00, ARM,  8'h00, 8'h00, 8'd0);
        tbl[24] = mk(1, 0, 0, 8'h08, ARM,  8'h00, 8'h00, 8'd0);
        tbl[25] = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h00, 8'd0);
        tbl[26] = mk(1, 0, 0, 8'h40, RUN,  8'h00, 8'h40, 8'd1);
        tbl[27] = mk(1, 0, 0, 8'h00, RUN,  8'h00, 8'h40, 8'd1);
        tbl[28] = mk(1, 0, 1, 8'h00, RUN,  8'h00, 8'h00, 8'd0);

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", bus.state,     OFF);
        chk("reset_out",   bus.pwm_out,   '0);
        chk("reset_fault", bus.fault,     '0);
        chk("reset_any",   bus.fault_any, 1'b0);
        chk("reset_cnt",   bus.fault_cnt, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) apply(tbl[i], i);

        // 2048-tick pulse on a 4096 period: mirrored, no fault.
        mism = 0; hi_cnt = 0;
        for (int k = 0; k < 2048; k++) begin
            drive(1'b1, 1'b0, 1'b0, p5);
            tick();
            if (bus.pwm_out !== p5) mism++;
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        chk("full_pulse_mirror", mism, 0);
        chk("full_pulse_end",    bus.pwm_out, '0);
        chk("full_pulse_fault",  bus.fault,   '0);

        // 2049-tick pulse: last tick suppressed and latched as fault.
        mism = 0;
        for (int k = 0; k < 2049; k++) begin
            drive(1'b1, 1'b0, 1'b0, p5);
            tick();
            if (bus.pwm_out[5]) hi_cnt++;
            if (bus.pwm_out[TRANS_NUM-1:6] !== '0 || bus.pwm_out[4:0] !== '0) mism++;
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        if (bus.pwm_out[5]) hi_cnt++;
        chk("over_pulse_hi_ticks", hi_cnt, 2048);
        chk("over_pulse_others",   mism, 0);
        chk("over_pulse_fault",    bus.fault, p5);
        chk("over_pulse_any",      bus.fault_any, 1'b1);
        chk("over_pulse_cnt",      bus.fault_cnt, 8'd1);
        chk("over_pulse_state",    bus.state, RUN);

        drive(1'b1, 1'b0, 1'b1, '0);
        tick();
        chk("clear_fault", bus.fault,     '0);
        chk("clear_cnt",   bus.fault_cnt, 8'd0);

        // ARM must hold while any input is high, then run after it falls.
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        chk("rearm_off", bus.state, OFF);
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        chk("rearm_arm", bus.state, ARM);
        mism = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b0, 1'b0, p3);
            tick();
            if (bus.state !== ARM || bus.pwm_out !== '0) mism++;
        end
        chk("arm_hold", mism, 0);
        drive(1'b1, 1'b0, 1'b0, '0);
        tick();
        chk("arm_to_run",  bus.state, RUN);
        chk("arm_nofault", bus.fault, '0);
        drive(1'b1, 1'b0, 1'b0, p3);
        tick();
        chk("run_first_pulse", bus.pwm_out, p3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
